// File: rtl/ps2_channel_sel.sv
// Channel select generator: debounced push-button steps merged with optional auto-scan steps,
// driving a wrapping 2-bit channel index with a one-cycle update strobe.
module ps2_channel_sel #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SCAN_PERIOD     = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_STEP,
    input  logic       SW_DIR,
    input  logic       SW_AUTO,
    output logic [1:0] SEL,
    output logic       SEL_STB
);

    localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned ScanW = $clog2(SCAN_PERIOD);
    localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_PERIOD - 1);

    typedef enum logic [1:0] {StUp, StDnWait, StDown, StUpWait} state_e;

    logic             key_meta_q, ks_q;
    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             press_step;
    logic [ScanW-1:0] presc_q, presc_d;
    logic             auto_step;
    logic             step_q;
    logic [1:0]       sel_q;
    logic             stb_q;

    // Synchronizer idles high so a reset never looks like a press.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_meta_q <= 1'b1;
            ks_q       <= 1'b1;
        end else begin
            key_meta_q <= KEY_STEP;
            ks_q       <= key_meta_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StUp;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        press_step = 1'b0;
        unique case (state_q)
            StUp: begin
                if (!ks_q) begin
                    state_d = StDnWait;
                    cnt_d   = CntW'(1);
                end
            end
            StDnWait: begin
                if (ks_q) begin
                    state_d = StUp;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d    = StDown;
                    cnt_d      = '0;
                    press_step = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDown: begin
                if (ks_q) begin
                    state_d = StUpWait;
                    cnt_d   = CntW'(1);
                end
            end
            StUpWait: begin
                // Falling back to DOWN is release bounce, not a new press.
                if (!ks_q) begin
                    state_d = StDown;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StUp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StUp;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        auto_step = SW_AUTO && (presc_q == ScanLast);
        if (!SW_AUTO || presc_q == ScanLast) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + ScanW'(1);
        end
    end

    // Both step sources are merged into one registered pulse, so coincident events step once.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q <= '0;
            step_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            step_q  <= press_step | auto_step;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_q <= 2'd0;
            stb_q <= 1'b0;
        end else begin
            stb_q <= step_q;
            if (step_q) begin
                sel_q <= SW_DIR ? sel_q + 2'd1 : sel_q - 2'd1;
            end
        end
    end

    assign SEL     = sel_q;
    assign SEL_STB = stb_q;

endmodule

// File: tb/tb_ps2_channel_sel.sv
// Bench for ps2_channel_sel: directed scenarios plus random stimulus, checked each cycle against
// a run-length / elapsed-time model of the select behaviour.
module tb_ps2_channel_sel;

    localparam int unsigned D = 4;
    localparam int unsigned P = 8;

    logic       clk;
    logic       rst_n;
    logic       key;
    logic       dir;
    logic       auto_en;
    logic [1:0] sel;
    logic       stb;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int m_sel, m_stb, m_pend;
    int h1, h2;
    int run_val, run_len, deb;
    int auto_run;

    ps2_channel_sel #(
        .DEBOUNCE_CYCLES(D),
        .SCAN_PERIOD    (P)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .KEY_STEP(key),
        .SW_DIR  (dir),
        .SW_AUTO (auto_en),
        .SEL     (sel),
        .SEL_STB (stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_stb = 0; m_pend = 0;
        h1 = 1; h2 = 1;
        run_val = 1; run_len = 0; deb = 1;
        auto_run = 0;
    endtask

    // One active edge with the given inputs applied beforehand.
    task automatic model_edge(input int k, input int a, input int d);
        int ks, press, autop;
        m_stb = m_pend;
        if (m_pend != 0) m_sel = (d != 0) ? (m_sel + 1) % 4 : (m_sel + 3) % 4;
        ks = h2; h2 = h1; h1 = k;
        if (ks == run_val) begin
            if (run_len < 1000) run_len++;
        end else begin
            run_val = ks;
            run_len = 1;
        end
        press = 0;
        // A level is accepted after D consecutive identical synchronized samples.
        if (run_len >= D && run_val != deb) begin
            deb   = run_val;
            press = (run_val == 0);
        end
        autop = 0;
        if (a != 0) begin
            auto_run++;
            autop = (auto_run % P == 0);
        end else begin
            auto_run = 0;
        end
        m_pend = press | autop;
    endtask

    task automatic tick(input logic k, input logic a, input logic d);
        key = k; auto_en = a; dir = d;
        @(posedge clk);
        model_edge(int'(k), int'(a), int'(d));
        #1;
        chk("sel", {6'd0, sel}, 8'(m_sel));
        chk("stb", {7'd0, stb}, 8'(m_stb));
    endtask

    task automatic press(input logic d, input logic a);
        for (int i = 0; i < 8; i++) tick(1'b0, a, d);
        for (int i = 0; i < 8; i++) tick(1'b1, a, d);
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_sel_async", {6'd0, sel}, 8'd0);
        chk("rst_stb_async", {7'd0, stb}, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_sel_hold", {6'd0, sel}, 8'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int s0;
        rst_n = 1'b0; key = 1'b1; dir = 1'b1; auto_en = 1'b0;
        model_reset();
        #1;
        chk("rst_sel_init", {6'd0, sel}, 8'd0);
        chk("rst_stb_init", {7'd0, stb}, 8'd0);
        @(posedge clk); @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
        chk("idle_sel", {6'd0, sel}, 8'd0);

        // Clean press held 20 cycles: update lands exactly 6 edges after key goes low.
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (i == 5) chk("press_before", {6'd0, sel}, 8'd0);
            if (i == 6) begin
                chk("press_sel", {6'd0, sel}, 8'd1);
                chk("press_stb", {7'd0, stb}, 8'd1);
            end
            if (i == 7) chk("press_stb_off", {7'd0, stb}, 8'd0);
        end
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b1);
        chk("release_sel", {6'd0, sel}, 8'd1);

        // Bounce: never D consecutive low samples.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b1);
        chk("bounce_sel", {6'd0, sel}, 8'd1);

        // Wrap in both directions.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("to3_sel", {6'd0, sel}, 8'd3);
        press(1'b1, 1'b0);
        chk("wrap_up", {6'd0, sel}, 8'd0);
        press(1'b0, 1'b0);
        chk("wrap_dn", {6'd0, sel}, 8'd3);
        press(1'b1, 1'b0);
        chk("back0", {6'd0, sel}, 8'd0);

        // Auto-scan from 0.
        for (int i = 0; i <= 32; i++) begin
            tick(1'b1, 1'b1, 1'b1);
            if (i == 7)  chk("auto_pre", {6'd0, sel}, 8'd0);
            if (i == 8)  chk("auto_1", {6'd0, sel}, 8'd1);
            if (i == 8)  chk("auto_stb", {7'd0, stb}, 8'd1);
            if (i == 16) chk("auto_2", {6'd0, sel}, 8'd2);
            if (i == 24) chk("auto_3", {6'd0, sel}, 8'd3);
            if (i == 32) chk("auto_0", {6'd0, sel}, 8'd0);
        end
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b1);
        chk("auto_off", {6'd0, sel}, 8'd0);

        // Press acceptance coincides with the first auto step: one step only.
        s0 = int'(sel);
        for (int i = 0; i < 14; i++) begin
            tick((i >= 2) ? 1'b0 : 1'b1, (i <= 9) ? 1'b1 : 1'b0, 1'b1);
            if (i == 8) begin
                chk("coin_sel", {6'd0, sel}, 8'((s0 + 1) % 4));
                chk("coin_stb", {7'd0, stb}, 8'd1);
            end
            if (i == 9) chk("coin_stb_off", {7'd0, stb}, 8'd0);
        end
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b1);
        chk("coin_after", {6'd0, sel}, 8'((s0 + 1) % 4));

        // Reset in the middle of a debounce count and a scan count.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1);
        async_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1);
        chk("post_rst_sel", {6'd0, sel}, 8'd0);

        // Random stimulus: slowly changing key and auto, free-running direction.
        begin
            logic k, a, d;
            k = 1'b1; a = 1'b0; d = 1'b1;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 5) == 0) k = ~k;
                if ($urandom_range(0, 40) == 0) a = ~a;
                if ($urandom_range(0, 10) == 0) d = ~d;
                tick(k, a, d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
